// File: rtl/hilo_reg_unit.sv
// HI/LO special-register unit: captures ALU results for MULT/MT*, runs DIV/DIVU
// as an iterative restoring divider (one quotient bit per cycle) while stalling the pipeline.
module hilo_reg_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  hilo_en,
  input  logic [4:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] alu_LO,
  input  logic [DATA_WIDTH-1:0] alu_HI,
  output logic [DATA_WIDTH-1:0] LO_q,
  output logic [DATA_WIDTH-1:0] HI_q,
  output logic                  stall,
  output logic                  div_done
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);

  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_FIX
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         counter;
  logic [DATA_WIDTH-1:0] quo, dvs, rem, a_raw;
  logic                  q_sign, r_sign, div_zero;

  logic                  div_start, is_signed;
  logic [DATA_WIDTH-1:0] a_mag, b_mag;
  logic [DATA_WIDTH:0]   shifted;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_step, quo_step, quo_fix, rem_fix;

  assign div_start = hilo_en && (alu_control == OP_DIV || alu_control == OP_DIVU);
  assign is_signed = (alu_control == OP_DIV);
  assign a_mag     = (is_signed && A[DATA_WIDTH-1]) ? -A : A;
  assign b_mag     = (is_signed && B[DATA_WIDTH-1]) ? -B : B;

  // The 33-bit partial remainder exists only as 'shifted'; after a restoring
  // step it always fits back into DATA_WIDTH bits because it is below the divisor.
  always_comb begin
    shifted  = {rem, quo[DATA_WIDTH-1]};
    ge       = (shifted >= {1'b0, dvs});
    rem_step = ge ? DATA_WIDTH'(shifted - {1'b0, dvs}) : shifted[DATA_WIDTH-1:0];
    quo_step = {quo[DATA_WIDTH-2:0], ge};
    quo_fix  = q_sign ? -quo : quo;
    rem_fix  = r_sign ? -rem : rem;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    div_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (div_start) begin
          stall     = 1'b1;
          state_nxt = S_DIV;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (counter == CW'(DATA_WIDTH - 1)) state_nxt = S_FIX;
      end
      S_FIX: begin
        stall     = 1'b1;
        div_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      counter  <= '0;
      LO_q     <= '0;
      HI_q     <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      a_raw    <= '0;
      q_sign   <= 1'b0;
      r_sign   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (hilo_en) begin
            case (alu_control)
              OP_MULT, OP_MULTU: begin
                LO_q <= alu_LO;
                HI_q <= alu_HI;
              end
              OP_MTLO: LO_q <= alu_LO;
              OP_MTHI: HI_q <= alu_HI;
              OP_DIV, OP_DIVU: begin
                quo      <= a_mag;
                dvs      <= b_mag;
                rem      <= '0;
                a_raw    <= A;
                q_sign   <= is_signed && (A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1]);
                r_sign   <= is_signed && A[DATA_WIDTH-1];
                div_zero <= (B == '0);
                counter  <= '0;
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          rem     <= rem_step;
          quo     <= quo_step;
          counter <= counter + 1'b1;
        end
        S_FIX: begin
          if (div_zero) begin
            LO_q <= '1;
            HI_q <= a_raw;
          end else begin
            LO_q <= quo_fix;
            HI_q <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_reg_unit.sv
// Randomized self-checking bench for hilo_reg_unit against an arithmetic
// reference of MIPS HI/LO semantics (64-bit signed divide, unsigned divide).
module tb_hilo_reg_unit;

  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MTLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hilo_en;
  logic [4:0]  alu_control;
  logic [31:0] A, B, alu_LO, alu_HI;
  logic [31:0] LO_q, HI_q;
  logic        stall, div_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_lo = '0;
  logic [31:0] exp_hi = '0;

  hilo_reg_unit #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hilo_en     (hilo_en),
    .alu_control (alu_control),
    .A           (A),
    .B           (B),
    .alu_LO      (alu_LO),
    .alu_HI      (alu_HI),
    .LO_q        (LO_q),
    .HI_q        (HI_q),
    .stall       (stall),
    .div_done    (div_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic void ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (op == OP_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic check_regs(input string tag);
    check_eq({tag, "_lo"}, LO_q, exp_lo);
    check_eq({tag, "_hi"}, HI_q, exp_hi);
  endtask

  // Called at posedge+1; leaves time at posedge+1 of the cycle after the operation.
  task automatic run_op(input string tag, input logic en, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lo, input logic [31:0] hi);
    int unsigned cnt;
    logic [31:0] q, r;
    alu_control = op; A = a; B = b; alu_LO = lo; alu_HI = hi; hilo_en = en;
    #1;
    if (en && (op == OP_DIV || op == OP_DIVU)) begin
      check_eq({tag, "_start_stall"}, 32'(stall), 32'd1);
      ref_div(op, a, b, q, r);
      @(posedge clk); #1;
      // garbage on the inputs while stalled must be ignored
      alu_control = OP_MULT; hilo_en = 1'b1;
      alu_LO = $urandom; alu_HI = $urandom; A = $urandom; B = $urandom;
      cnt = 1;
      while (stall && cnt < 100) begin
        cnt++;
        check_eq({tag, "_div_done"}, 32'(div_done), 32'(cnt == 34));
        @(posedge clk); #1;
      end
      check_eq({tag, "_stall_len"}, cnt, 32'd34);
      hilo_en = 1'b0;
      exp_lo = q;
      exp_hi = r;
      check_regs(tag);
    end else begin
      check_eq({tag, "_no_stall"}, 32'(stall), 32'd0);
      if (en) begin
        case (op)
          OP_MULT, OP_MULTU: begin exp_lo = lo; exp_hi = hi; end
          OP_MTLO: exp_lo = lo;
          OP_MTHI: exp_hi = hi;
          default: ;
        endcase
      end
      @(posedge clk); #1;
      hilo_en = 1'b0;
      check_regs(tag);
    end
  endtask

  task automatic reset_now(input string tag);
    reset_n = 1'b0;
    #1;
    exp_lo = '0;
    exp_hi = '0;
    check_regs(tag);
    check_eq({tag, "_stall"}, 32'(stall), 32'd0);
    check_eq({tag, "_done"}, 32'(div_done), 32'd0);
    hilo_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [4:0] op_tab [8] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTLO, OP_MTHI, 5'b00000, 5'b10100};

  initial begin
    int unsigned cnt;
    logic [31:0] a, b;
    reset_n = 1'b1; hilo_en = 1'b0; alu_control = '0;
    A = '0; B = '0; alu_LO = '0; alu_HI = '0;
    #1 reset_n = 1'b0;
    #1;
    check_regs("reset0");
    check_eq("reset0_stall", 32'(stall), 32'd0);
    check_eq("reset0_done", 32'(div_done), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult", 1'b1, OP_MULT, 32'd0, 32'd0, 32'h0000_1234, 32'h0000_ABCD);
    check_eq("mult_lit_lo", LO_q, 32'h0000_1234);
    run_op("mtlo", 1'b1, OP_MTLO, 32'd0, 32'd0, 32'h55, 32'h99);
    check_eq("mtlo_lit_hi", HI_q, 32'h0000_ABCD);
    run_op("mthi", 1'b1, OP_MTHI, 32'd0, 32'd0, 32'h33, 32'h77);
    check_eq("mthi_lit_lo", LO_q, 32'h55);

    @(negedge clk); #1;
    reset_now("reset_mid");

    run_op("div_m7_2", 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    check_eq("div_m7_2_lit", LO_q, 32'hFFFF_FFFD);
    run_op("divu_7_2", 1'b1, OP_DIVU, 32'd7, 32'd2, 32'd0, 32'd0);
    run_op("div_ovf", 1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    check_eq("div_ovf_lit", LO_q, 32'h8000_0000);
    run_op("divu_5_0", 1'b1, OP_DIVU, 32'd5, 32'd0, 32'd0, 32'd0);
    run_op("div_m7_0", 1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0);
    check_eq("div_m7_0_lit", HI_q, 32'hFFFF_FFF9);

    // reset while on DIV cycle 10
    alu_control = OP_DIV; A = 32'd1000; B = 32'd3; hilo_en = 1'b1;
    @(posedge clk); #1;
    hilo_en = 1'b0;
    cnt = 1;
    while (stall && cnt < 9) begin cnt++; @(posedge clk); #1; end
    check_eq("abort_in_div", 32'(stall), 32'd1);
    #2;
    reset_now("abort");
    run_op("post_abort", 1'b1, OP_MULT, 32'd0, 32'd0, 32'd1, 32'd2);
    check_eq("post_abort_lit", HI_q, 32'd2);

    for (int i = 0; i < 60; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: a = $signed(a) >>> $urandom_range(0, 31);
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op("rand", ($urandom_range(0, 7) != 0), op_tab[$urandom_range(0, 7)],
             a, b, $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
